// File: rtl/bhv_resp_check_if.sv
// rtl/bhv_resp_check_if.sv - sample/result bundle between a stimulus source and the response checker
interface bhv_resp_check_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             inValid;
   logic [WIDTH-1:0] inp;
   logic             busy;
   logic             done;
   logic             pass;
   logic             timeout;
   logic             mismatch;
   logic [15:0]      errCnt;
   logic [15:0]      firstErrIdx;

   modport master (
      output start, inValid, inp,
      input  busy, done, pass, timeout, mismatch, errCnt, firstErrIdx
   );

   modport slave (
      input  start, inValid, inp,
      output busy, done, pass, timeout, mismatch, errCnt, firstErrIdx
   );
endinterface

// File: rtl/bhv_resp_check.sv
// rtl/bhv_resp_check.sv - checks a sample stream against a Dirac, step or LFSR reference
module bhv_resp_check #(
   parameter int          TYPE     = 0,
   parameter int          WIDTH    = 8,
   parameter int          AMPL     = 0,
   parameter int          NEG_AMPL = 0,
   parameter int          LENGTH   = 100,
   parameter logic [31:0] SEED     = 32'h55555555,
   parameter logic [31:0] TAPS     = 32'b1000000100,
   parameter int          TIMEOUT  = 1000
) (
   input  logic            clk,
   input  logic            nGrst,
   input  logic            rst,
   input  logic            clkEn,
   bhv_resp_check_if.slave bus
);

   // Dirac needs room for both impulses; the other patterns run LENGTH past the 11-sample lead-in.
   localparam int               N_SAMP = (TYPE == 0) ? (11 + 2 * LENGTH) : (11 + LENGTH);
   localparam logic [15:0]      K_LAST = 16'(N_SAMP - 1);
   localparam logic [15:0]      K_NEG  = 16'(10 + LENGTH);
   localparam logic [31:0]      TO_L   = 32'(TIMEOUT);
   localparam logic [WIDTH-1:0] A_POS  = (AMPL != 0) ? {1'b0, {(WIDTH-1){1'b1}}} : WIDTH'(1);
   localparam logic [WIDTH-1:0] A_NEG  = WIDTH'(~A_POS + WIDTH'(1));

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_start_d;
   logic             r_start_pend;
   logic [15:0]      r_k;
   logic [15:0]      r_err_cnt;
   logic [15:0]      r_first_err;
   logic [31:0]      r_tcnt;
   logic [WIDTH-1:0] r_lfsr;
   logic [WIDTH-1:0] w_lfsr_nxt;
   logic [WIDTH-1:0] w_exp;
   logic             w_fb;
   logic             r_done;
   logic             r_pass;
   logic             r_timeout;
   logic             r_mismatch;
   logic             w_srst;
   logic             w_start_edge;
   logic             w_init;
   logic             w_accept;
   logic             w_last;
   logic             w_to_hit;
   logic             w_mis;

   assign w_srst       = rst & clkEn;
   assign w_start_edge = bus.start & ~r_start_d;
   assign w_mis        = w_accept & (bus.inp != w_exp);

   // Catch a start edge on any clk; it waits for an enabled cycle outside DONE to be consumed,
   // so a start seen during DONE takes effect in the following IDLE cycle.
   always_ff @(posedge clk or negedge nGrst) begin
      if (!nGrst) begin
         r_start_d    <= 1'b0;
         r_start_pend <= 1'b0;
      end else begin
         r_start_d <= bus.start;
         if (w_srst)
            r_start_pend <= 1'b0;
         else if (w_start_edge)
            r_start_pend <= 1'b1;
         else if (clkEn && (r_state != S_DONE))
            r_start_pend <= 1'b0;
      end
   end

   // Reference LFSR step: feedback also injects a 1 when the low bits are all zero.
   always_comb begin
      w_lfsr_nxt    = '0;
      w_fb          = r_lfsr[WIDTH-1] ^ ~(|r_lfsr[WIDTH-2:0]);
      w_lfsr_nxt[0] = w_fb;
      for (int n = 1; n < WIDTH; n++)
         w_lfsr_nxt[n] = r_lfsr[n-1] ^ (TAPS[n-1] & w_fb);
   end

   // Expected sample for the current index.
   always_comb begin
      w_exp = '0;
      if (TYPE == 0) begin
         if (r_k == 16'd10)
            w_exp = A_POS;
         else if (r_k == K_NEG)
            w_exp = A_NEG;
      end else if (TYPE == 1) begin
         w_exp = (NEG_AMPL != 0) ? A_NEG : A_POS;
      end else begin
         w_exp = r_lfsr;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge nGrst) begin
      if (!nGrst)
         r_state <= S_IDLE;
      else if (w_srst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next state and per-cycle strobes; a pending start in RUN wins over a sample.
   always_comb begin
      w_state_nxt = r_state;
      w_init      = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      w_to_hit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (clkEn && r_start_pend) begin
               w_state_nxt = S_RUN;
               w_init      = 1'b1;
            end
         end
         S_RUN: begin
            if (clkEn) begin
               if (r_start_pend) begin
                  w_init = 1'b1;
               end else if (bus.inValid) begin
                  w_accept = 1'b1;
                  if (r_k == K_LAST) begin
                     w_last      = 1'b1;
                     w_state_nxt = S_DONE;
                  end
               end else if ((r_tcnt + 32'd1) >= TO_L) begin
                  w_to_hit    = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (clkEn)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Check datapath: index, error statistics, timeout counter and result flags.
   always_ff @(posedge clk or negedge nGrst) begin
      if (!nGrst) begin
         r_k         <= '0;
         r_err_cnt   <= '0;
         r_first_err <= 16'hFFFF;
         r_tcnt      <= '0;
         r_lfsr      <= SEED[WIDTH-1:0];
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_timeout   <= 1'b0;
         r_mismatch  <= 1'b0;
      end else if (w_srst) begin
         r_k         <= '0;
         r_err_cnt   <= '0;
         r_first_err <= 16'hFFFF;
         r_tcnt      <= '0;
         r_lfsr      <= SEED[WIDTH-1:0];
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_timeout   <= 1'b0;
         r_mismatch  <= 1'b0;
      end else begin
         r_mismatch <= w_mis;
         r_done     <= w_last | w_to_hit;
         if (w_init) begin
            r_k         <= '0;
            r_err_cnt   <= '0;
            r_first_err <= 16'hFFFF;
            r_tcnt      <= '0;
            r_lfsr      <= SEED[WIDTH-1:0];
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
         end else if (w_accept) begin
            r_k    <= r_k + 16'd1;
            r_tcnt <= '0;
            r_lfsr <= w_lfsr_nxt;
            if (w_mis) begin
               if (r_err_cnt != 16'hFFFF)
                  r_err_cnt <= r_err_cnt + 16'd1;
               if (r_first_err == 16'hFFFF)
                  r_first_err <= r_k;
            end
            if (w_last)
               r_pass <= (r_err_cnt == 16'd0) && !w_mis;
         end else if ((r_state == S_RUN) && clkEn) begin
            r_tcnt <= r_tcnt + 32'd1;
            if (w_to_hit) begin
               r_timeout <= 1'b1;
               r_pass    <= 1'b0;
            end
         end
      end
   end

   assign bus.busy        = (r_state == S_RUN);
   assign bus.done        = r_done;
   assign bus.pass        = r_pass;
   assign bus.timeout     = r_timeout;
   assign bus.mismatch    = r_mismatch;
   assign bus.errCnt      = r_err_cnt;
   assign bus.firstErrIdx = r_first_err;

endmodule

// File: doc/bhv_resp_check.md
BHV_RESP_CHECK -- requirements
Module: bhv_resp_check

Interface
REQ-001 Parameters SHALL be:
- TYPE, 0: 0=Dirac, 1=step, 2=LFSR expected pattern
- WIDTH, 8: sample width, 2..32
- AMPL, 0: 0 = amplitude 1; 1 = amplitude 2^(WIDTH-1)-1
- NEG_AMPL, 0: step only; 1 negates the amplitude
- LENGTH, 100: sequence length parameter
- SEED, 32'h55555555: LFSR seed, low WIDTH bits used
- TAPS, 10'b1000000100: LFSR tap mask, WIDTH bits
- TIMEOUT, 1000: maximum clkEn cycles between valid samples
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock
- nGrst, in, 1: asynchronous active-low reset
- rst, in, 1: synchronous reset, qualified by clkEn
- clkEn, in, 1: clock enable
- start, in, 1: arm pulse, any width, any cycle
- inValid, in, 1: inp carries a sample this clkEn cycle
- inp, in, WIDTH: sample under test, two's complement
- busy, out, 1: check in progress
- done, out, 1: one-clk pulse at end of check
- pass, out, 1: last check error-free and not timed out
- timeout, out, 1: last check aborted by timeout
- mismatch, out, 1: registered flag for the previous accepted sample
- errCnt, out, 16: mismatches in the current or last check, saturating
- firstErrIdx, out, 16: index of the first mismatch; 16'hFFFF if none

Function
REQ-003 A start rising edge SHALL be latched on clk regardless of clkEn, and consumed at the next clkEn=1 cycle.
REQ-004 The FSM SHALL have three states, all transitions on clkEn=1 cycles only:
- IDLE -> RUN on a consumed start
- RUN -> DONE after the last sample or on timeout
- DONE -> IDLE unconditionally
REQ-005 On entry to RUN the block SHALL clear k (sample index), errCnt and the timeout counter, set firstErrIdx=FFFF, load the LFSR with SEED, and drive busy=1.
REQ-006 In RUN, a sample SHALL be accepted when clkEn & inValid; each acceptance SHALL increment k, compare inp with exp(k), and advance the LFSR.
REQ-007 The expected value exp(k) SHALL be:
- Dirac (A = amplitude): +A at k=10, -A at k=10+LENGTH, else 0; N = 11+2*LENGTH samples
- step: +/-A for all k; N = 11+LENGTH
- LFSR: the current register value; N = 11+LENGTH
REQ-008 The LFSR next state SHALL be computed as:
- fb = r[W-1] XOR NOR(r[W-2:0])
- next[0] = fb
- next[n] = r[n-1] XOR (TAPS[n-1] AND fb), for n = 1..W-1
REQ-009 Comparison SHALL be full-width bitwise; arithmetic negation SHALL wrap at WIDTH bits.
REQ-010 On a mismatch:
- mismatch SHALL assert for 1 clk on the cycle after acceptance
- errCnt SHALL increment, saturating at FFFF
- firstErrIdx SHALL capture k only if it is still FFFF
REQ-011 Acceptance of sample k=N-1 SHALL move the FSM to DONE; further inValid SHALL be ignored until the next start.
REQ-012 The timeout counter SHALL count clkEn cycles without acceptance and clear on each acceptance; reaching TIMEOUT SHALL set timeout=1 and move the FSM to DONE.
REQ-013 In DONE, done SHALL pulse for exactly one clk and busy SHALL drop.
REQ-014 pass SHALL be set to (errCnt==0 && !timeout) in DONE.
REQ-015 pass, timeout, errCnt and firstErrIdx SHALL hold until the next RUN entry.
REQ-016 A start consumed in RUN SHALL abort the current check without a done pulse and restart per REQ-005.
REQ-017 A start consumed in DONE SHALL be acted on in the following IDLE cycle.
REQ-018 Latency SHALL be: done asserts 1 clk after the clkEn cycle that accepts the last sample.

Reset
REQ-019 On nGrst=0 the block SHALL asynchronously:
- set the FSM to IDLE
- clear busy, done, pass, timeout, mismatch and errCnt
- set firstErrIdx=FFFF and clear the start latch
- load the LFSR with SEED
REQ-020 rst=1 with clkEn=1 SHALL apply the same state synchronously, including mid-RUN; no done pulse SHALL be generated.

Verification
REQ-021 TYPE=0, WIDTH=8, LENGTH=4, AMPL=0, with an ideal Dirac stream of 19 samples (1 at k=10, FF at k=14) -> done pulses once, pass=1, errCnt=0, firstErrIdx=FFFF.
REQ-022 Same as REQ-021 with inp=02 at k=10 -> mismatch pulses once, errCnt=1, firstErrIdx=10, pass=0.
REQ-023 TYPE=2, WIDTH=10, with a stream from an identical LFSR but inValid gapped randomly with clkEn at 1/3 rate -> pass=1 after 111 samples.
REQ-024 TIMEOUT=20, stop driving inValid after 5 samples -> timeout=1 and done exactly 20 clkEn cycles after the last acceptance, pass=0.
REQ-025 Start re-pulsed at k=7 -> no done, counters clear, and the subsequent full correct stream gives pass=1.
REQ-026 nGrst pulsed low mid-RUN -> all outputs at reset values immediately; no done until a new start.
